// File: rtl/jesd204_rx_capture.sv
// rtl/jesd204_rx_capture.sv - JESD204 RX snapshot buffer with per-lane frame-error and sync-loss counters
// Register and buffer access over the PicoRV32 packed MEM bus.
module jesd204_rx_capture #(
    parameter int         LANES      = 4,
    parameter int         DEPTH_LOG2 = 10,
    parameter int         ERRCNT_W   = 16,
    parameter logic [7:0] BASE_ADDR  = 8'h04,
    parameter logic [7:0] BASE2_ADDR = 8'h01
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [68:0]           mem_packed_fwd,
    output logic [32:0]           mem_packed_ret,
    input  logic [32*LANES-1:0]   rx_tdata,
    input  logic                  rx_tvalid,
    input  logic [LANES-1:0]      rx_start_of_multiframe,
    input  logic [4*LANES-1:0]    rx_frame_error,
    input  logic                  rx_sync,
    output logic                  capture_done
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int WORDS = DEPTH * LANES;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_TRIG, S_CAPTURE, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [DEPTH_LOG2-1:0]   r_wptr, w_wptr_nxt;
    logic                    w_ram_we;

    logic [31:0]  w_wdata, w_addr;
    logic [3:0]   w_wstrb;
    logic         w_valid, w_sel, w_accept;
    logic         r_busy, r_p1;
    logic [15:0]  r_addr;
    logic [31:0]  r_wdata;
    logic [3:0]   r_wstrb;
    logic         w_wr, w_ctrl_wr, w_arm, w_clr;
    logic         r_mode, r_ready, r_is_buf;
    logic [2:0]   r_lane_sel, w_rd_lane;
    logic [31:0]  r_rdata_reg, w_reg_rdata, w_buf_q, w_word;
    logic         w_buf_hit;
    logic [DEPTH_LOG2-1:0] w_rd_beat;
    logic [31:0]  w_lane_q [LANES];

    logic [ERRCNT_W-1:0] r_errcnt [LANES];
    logic [ERRCNT_W-1:0] r_syncloss;
    logic                r_sync_q, r_sync_primed;
    logic                w_unused;

    assign {w_wdata, w_wstrb, w_valid, w_addr} = mem_packed_fwd;
    assign w_sel    = w_valid && (w_addr[31:16] == {BASE_ADDR, BASE2_ADDR});
    assign w_accept = w_sel && !r_busy;
    assign w_unused = &{1'b0, rx_start_of_multiframe, r_wdata[31:3]};

    // Stage 1: latch the request once; busy holds off a repeat until mem_valid drops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy  <= 1'b0;
            r_p1    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else begin
            r_p1 <= w_accept;
            if (w_accept) begin
                r_busy  <= 1'b1;
                r_addr  <= w_addr[15:0];
                r_wdata <= w_wdata;
                r_wstrb <= w_wstrb;
            end else if (!w_valid) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign w_wr      = r_p1 && (r_wstrb != 4'b0);
    assign w_ctrl_wr = w_wr && (r_addr == 16'h0000) && r_wstrb[0];
    assign w_arm     = w_ctrl_wr && r_wdata[0];
    assign w_clr     = w_ctrl_wr && r_wdata[2];

    assign w_word    = {19'b0, r_addr[14:2]};
    assign w_buf_hit = r_addr[15] && (w_word < 32'(WORDS));
    assign w_rd_beat = DEPTH_LOG2'(w_word / 32'(LANES));
    assign w_rd_lane = 3'(w_word % 32'(LANES));

    always_comb begin
        w_reg_rdata = '0;
        case (r_addr)
            16'h0000: w_reg_rdata = {30'b0, r_mode, 1'b0};
            16'h0004: w_reg_rdata = {28'b0, r_state == S_DONE, r_state == S_CAPTURE,
                                     r_state == S_WAIT_TRIG, rx_sync};
            16'h0008: w_reg_rdata = 32'(r_syncloss);
            default: begin
                for (int l = 0; l < LANES; l++)
                    if (r_addr == 16'(16 + 4 * l)) w_reg_rdata = 32'(r_errcnt[l]);
            end
        endcase
    end

    // Stage 2: response, control side effects and the buffer read all land on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready     <= 1'b0;
            r_is_buf    <= 1'b0;
            r_lane_sel  <= '0;
            r_rdata_reg <= '0;
            r_mode      <= 1'b0;
        end else begin
            r_ready     <= r_p1;
            r_is_buf    <= w_buf_hit;
            r_lane_sel  <= w_rd_lane;
            r_rdata_reg <= w_reg_rdata;
            if (w_ctrl_wr) r_mode <= r_wdata[1];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0] r_mem [DEPTH];
        logic [31:0] r_q;
        always_ff @(posedge clk) begin
            if (w_ram_we) r_mem[r_wptr] <= rx_tdata[32*l +: 32];
            r_q <= r_mem[w_rd_beat];
        end
        assign w_lane_q[l] = r_q;
    end

    always_comb begin
        w_buf_q = '0;
        for (int l = 0; l < LANES; l++)
            if (r_lane_sel == 3'(l)) w_buf_q = w_lane_q[l];
    end

    assign mem_packed_ret = {r_ready, r_ready ? (r_is_buf ? w_buf_q : r_rdata_reg) : 32'b0};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wptr  <= w_wptr_nxt;
        end
    end

    // The trigger beat is written at wptr, which ARM has already zeroed.
    always_comb begin
        w_state_nxt = r_state;
        w_wptr_nxt  = r_wptr;
        w_ram_we    = 1'b0;
        if (w_arm) begin
            w_state_nxt = S_WAIT_TRIG;
            w_wptr_nxt  = '0;
        end else begin
            case (r_state)
                S_WAIT_TRIG: begin
                    if (!r_mode) begin
                        w_state_nxt = S_CAPTURE;
                    end else if (rx_tvalid && rx_start_of_multiframe[0]) begin
                        w_ram_we    = 1'b1;
                        w_state_nxt = (&r_wptr) ? S_DONE : S_CAPTURE;
                        w_wptr_nxt  = (&r_wptr) ? r_wptr : r_wptr + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (rx_tvalid) begin
                        w_ram_we    = 1'b1;
                        w_state_nxt = (&r_wptr) ? S_DONE : S_CAPTURE;
                        w_wptr_nxt  = (&r_wptr) ? r_wptr : r_wptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign capture_done = (r_state == S_DONE);

    // The first sample after reset only seeds the sync history, so a link still down is not a loss.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int l = 0; l < LANES; l++) r_errcnt[l] <= '0;
            r_syncloss    <= '0;
            r_sync_q      <= 1'b1;
            r_sync_primed <= 1'b0;
        end else begin
            r_sync_q      <= rx_sync;
            r_sync_primed <= 1'b1;
            for (int l = 0; l < LANES; l++) begin
                if (w_clr)
                    r_errcnt[l] <= '0;
                else if (rx_tvalid && (|rx_frame_error[4*l +: 4]) && !(&r_errcnt[l]))
                    r_errcnt[l] <= r_errcnt[l] + 1'b1;
            end
            if (w_clr)
                r_syncloss <= '0;
            else if (r_sync_primed && r_sync_q && !rx_sync && !(&r_syncloss))
                r_syncloss <= r_syncloss + 1'b1;
        end
    end
endmodule
